// File: rtl/dff_arb_pkg.sv
// dff_arb_pkg
// Shared definitions for the DFF register-bank arbiter slice.
//   N_DEF, W_DEF, DEPTH_DEF : default requester count, data width, bank depth
//   rr_ptr_t                : round-robin pointer / requester index (covers up to 16 requesters)
//   onehot_to_idx           : converts a one-hot vector (up to 16 bits) to its bit index
package dff_arb_pkg;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 8;
    localparam int DEPTH_DEF = 8;

    typedef logic [3:0] rr_ptr_t;

    // ORs together the index of every set bit; for a one-hot input this is
    // exactly the index of the single set bit, and an all-zero input gives 0.
    function automatic rr_ptr_t onehot_to_idx(input logic [15:0] oh);
        rr_ptr_t idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | rr_ptr_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// N-input round-robin arbiter with a per-requester mask and a registered pointer.
// Ports:
//   clk, clr   : clock (rising edge) and asynchronous active-high reset
//   req[N]     : raw request vector
//   mask[N]    : requesters excluded from this cycle's arbitration
//   win_oh[N]  : combinational one-hot winner
//   win_idx    : combinational index of the winner (0 when none)
//   win_any    : high when some requester won
module rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] win_oh,
    output rr_ptr_t      win_idx,
    output logic         win_any
);

    rr_ptr_t      ptr;
    logic [N-1:0] elig;
    logic [15:0]  oh_ext;
    logic         found;

    assign elig = req & ~mask;

    // Winner search in two passes: first the requesters at or above the
    // pointer, then (only if none of those were eligible) the ones below it.
    // Together this is the upward search from the pointer wrapping at N-1.
    always_comb begin
        win_oh = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && elig[k] && (k >= int'(ptr))) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!found && elig[k]) begin
                found     = 1'b1;
                win_oh[k] = 1'b1;
            end
        end
    end

    // Widen the winner to the helper's fixed 16-bit input before indexing it.
    always_comb begin
        oh_ext         = '0;
        oh_ext[N-1:0]  = win_oh;
    end

    assign win_idx = onehot_to_idx(oh_ext);
    assign win_any = found;

    // The pointer moves to just past the winner so that requester drops to
    // lowest priority next time; with no winner the pointer holds.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr <= '0;
        end else if (win_any) begin
            ptr <= (int'(win_idx) == N - 1) ? '0 : win_idx + rr_ptr_t'(1);
        end
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
// Shares one bank of DEPTH W-bit registers between N write requesters using
// round-robin arbitration, with a single registered read port.
// Ports:
//   clk, clr          : clock (rising edge) and asynchronous active-high reset
//   req[N]            : level write request per requester
//   wr_addr[N*AW]     : per-requester address, slice k at [k*AW +: AW]
//   wr_data[N*W]      : per-requester data, slice k at [k*W +: W]
//   gnt[N]            : one-hot pulse, that requester's write has landed
//   gnt_id            : index of the granted requester
//   busy              : some eligible request is pending
//   rd_addr, rd_data  : read address and registered (1-cycle) read data
module dff_bank_arbiter
    import dff_arb_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int W     = W_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int GIW   = $clog2(N)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [N-1:0]    req,
    input  logic [N*AW-1:0] wr_addr,
    input  logic [N*W-1:0]  wr_data,
    output logic [N-1:0]    gnt,
    output logic [GIW-1:0]  gnt_id,
    output logic            busy,
    input  logic [AW-1:0]   rd_addr,
    output logic [W-1:0]    rd_data
);

    logic [N-1:0]            win_oh;
    rr_ptr_t                 win_idx;
    logic                    win_any;
    logic [AW-1:0]           waddr;
    logic [W-1:0]            wdata;
    logic [DEPTH-1:0][W-1:0] bank;

    // The requester granted last cycle is masked so a held req is not
    // counted twice while its grant is showing.
    rr_arbiter #(.N(N)) u_arb (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .mask    (gnt),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    assign busy  = |(req & ~gnt);
    assign waddr = wr_addr[int'(win_idx)*AW +: AW];
    assign wdata = wr_data[int'(win_idx)*W +: W];

    // Each bank entry is a plain DFF; the write enable is a hold mux on its
    // d input that recirculates the current value unless this entry is the
    // winner's target.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        logic [W-1:0] q;
        logic [W-1:0] d;

        always_comb begin
            d = (win_any && (waddr == AW'(g))) ? wdata : q;
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end

        assign bank[g] = q;
    end

    // Grant outputs are registered alongside the commit, so a visible grant
    // always means the data is already in the bank.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            gnt    <= win_oh;
            gnt_id <= win_idx[GIW-1:0];
        end
    end

    // Read samples the bank before this edge's write lands, so a same-address
    // write shows up one edge later.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_data <= '0;
        end else begin
            rd_data <= bank[rd_addr];
        end
    end

endmodule
